rr_arbiter_burst: RTL and testbench
===================================

Name: rr_arbiter_burst

Overview:
- Clocked, parametrised round-robin arbiter for N requesters with an ack handshake and a bounded burst per grant.
- Successor to the two-port, ack-edge-driven arbiter:
  - fully synchronous to clk;
  - registered one-hot grant plus encoded grant index;
  - the grant is held across up to MAX_BURST acknowledged transfers before rotating.
- Sits between N bus masters and a single shared slave port; the slave returns ack once per completed transfer.

Parameters:
- N, 4, number of requesters (>=2).
- MAX_BURST, 4, maximum acks per grant before forced rotation (>=1).
- IDW, $clog2(N), width of grant_id.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  request vector; bit i high = requester i wants the port.
- ack  in  1  one transfer completed by the currently granted requester (ignored when no grant is active).
- grant  out  N  registered one-hot grant; all-zero when idle.
- grant_id  out  IDW  index of the granted requester; 0 when idle.
- grant_valid  out  1  OR of grant.

Behaviour:
- Reset:
  - grant=0, grant_id=0, grant_valid=0, state=IDLE.
  - pointer=0 (requester 0 has highest priority), burst_cnt=0.
  - Reset asserted mid-burst aborts the grant on the next edge; no ack is counted in that cycle.
- Priority pick, combinational:
  - The winner is the first set bit of req searching upward from pointer, wrapping from N-1 to 0.
  - No set bit means no winner.
- State IDLE:
  - If any req bit is set, register the winner into grant/grant_id, set burst_cnt=0, go to GRANT.
  - Latency from req rising to grant: 1 cycle.
- State GRANT:
  - Grant is held stable. ack increments burst_cnt (saturating width $clog2(MAX_BURST+1)).
- Release conditions, evaluated in the same cycle:
  - (a) ack with burst_cnt==MAX_BURST-1;
  - (b) ack while req[grant_id]==0;
  - (c) req[grant_id]==0 without ack (requester abandons).
- On release:
  - pointer <= grant_id+1 mod N.
  - Re-arbitrate in the same cycle using the new pointer, with the released requester's bit masked for that cycle only.
  - If a winner exists, grant it on the next edge and stay in GRANT with burst_cnt=0. This gives a zero-bubble handover: grant changes directly from one one-hot value to another.
  - Otherwise grant=0 and go to IDLE.
- A single requester asserting continuously is re-granted after the one-cycle mask, so it sees one idle cycle every MAX_BURST transfers.
- ack in IDLE: ignored, no state change.
- New requests that arrive during GRANT never preempt the current grant.
- grant is always one-hot or zero; grant_id is consistent with grant in every cycle.

Optional Feature:
- Macro ARB_LOCK_EN.
- When defined, adds input lock (1 bit). While lock=1 in GRANT, release condition (a) is suppressed and burst_cnt saturates at MAX_BURST-1, so the grant persists until lock=0 and the next qualifying release. Conditions (b) and (c) still release.
- When undefined, the port is absent and behaviour is as above.

Decomposition:
- Package arb_pkg:
  - state enum {IDLE, GRANT};
  - function for index width (clog2 with minimum 1);
  - function mod-N increment.
- One sub-module, arb_rr_pick: combinational rotate-priority picker.
  - Inputs: req, pointer, mask.
  - Outputs: winner one-hot, winner index, any.
  - Implemented via double-width request vector and subtract-and-mask.

Test Plan:
- Reset then req=4'b0000 for 10 cycles -> grant=0, grant_valid=0 throughout; pulse ack -> no change.
- req=4'b1010 from pointer 0 -> grant=4'b0010 one cycle later. After 4 acks (MAX_BURST=4): grant=4'b1000 on the next edge with no idle cycle, and pointer=2 at handover.
- req=4'b1111 held, ack every cycle -> grant sequence 0001,0010,0100,1000,0001, each held exactly 4 acks.
- Granted requester 2 drops req without ack -> grant leaves bit 2 on the next edge; pointer=3.
- rst asserted during burst_cnt=2 -> next edge grant=0, pointer=0; deassert with req=4'b0100 -> grant=4'b0100 one cycle later.
- ARB_LOCK_EN: req=4'b0011, lock=1, 10 acks to requester 0 -> grant stays 4'b0001; lock=0 with ack -> grant=4'b0010 next edge.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the burst round-robin arbiter.
//   arb_state_e : controller state (IDLE, GRANT)
//   idx_width() : bits needed to index n items, never less than 1
//   mod_inc()   : (idx + 1) mod n, used to advance the rotating pointer
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    if (n > 32'd2) begin
      idx_width = $clog2(n);
    end else begin
      idx_width = 32'd1;
    end
  endfunction

  function automatic int unsigned mod_inc(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      mod_inc = 32'd0;
    end else begin
      mod_inc = idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational rotate-priority picker.
// Finds the first set bit of (req & ~mask) searching upward from pointer and
// wrapping from N-1 to 0.
//   req       in  N    request vector
//   pointer   in  IDW  index with highest priority
//   mask      in  N    requesters excluded from this pick
//   winner    out N    one-hot winner (zero when nothing is eligible)
//   winner_id out IDW  index of winner (zero when nothing is eligible)
//   any       out 1    at least one eligible requester
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = idx_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] pointer,
  input  logic [N-1:0]   mask,
  output logic [N-1:0]   winner,
  output logic [IDW-1:0] winner_id,
  output logic           any
);

  logic [N-1:0]   elig_s;
  logic [2*N-1:0] base_s;
  logic [2*N-1:0] dbl_s;
  logic [2*N-1:0] below_s;
  logic [2*N-1:0] cand_s;
  logic [2*N-1:0] first_s;

  // Doubling the vector turns the wrap-around search into a plain lowest-bit
  // search: the upper copy holds every requester at an offset >= pointer.
  always_comb begin
    elig_s  = req & ~mask;
    base_s  = {{(2*N-1){1'b0}}, 1'b1};
    dbl_s   = {elig_s, elig_s};
    // Thermometer of positions below pointer, removed from the candidates.
    below_s = (base_s << pointer) - base_s;
    cand_s  = dbl_s & ~below_s;
    // x & -x isolates the lowest set bit.
    first_s = cand_s & (~cand_s + base_s);
    winner  = first_s[N-1:0] | first_s[2*N-1:N];
    any     = |elig_s;
  end

  // One-hot to index encoder; OR-reduction is safe because winner is one-hot.
  always_comb begin
    winner_id = {IDW{1'b0}};
    for (int i = 0; i < N; i++) begin
      winner_id = winner_id | (winner[i] ? IDW'(i) : {IDW{1'b0}});
    end
  end

endmodule

// File: rtl/rr_arbiter_burst.sv
// Round-robin arbiter for N masters sharing one slave port. A grant is held
// for up to MAX_BURST acknowledged transfers, then rotates with a zero-bubble
// handover when another requester is waiting.
// Optional build macro ARB_LOCK_EN adds the 'lock' input, which suppresses
// the burst-length release while high.
//   clk         in  1    clock, rising edge
//   rst         in  1    synchronous active-high reset
//   req         in  N    request vector
//   ack         in  1    transfer completed by the granted requester
//   lock        in  1    (ARB_LOCK_EN only) hold grant past MAX_BURST
//   grant       out N    registered one-hot grant, zero when idle
//   grant_id    out IDW  index of granted requester, zero when idle
//   grant_valid out 1    any grant active
module rr_arbiter_burst
  import arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 4,
  parameter int IDW       = idx_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           ack,
`ifdef ARB_LOCK_EN
  input  logic           lock,
`endif
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  arb_state_e     state_r;
  arb_state_e     state_nxt_s;
  logic [IDW-1:0] pointer_r;
  logic [IDW-1:0] pointer_nxt_s;
  logic [CW-1:0]  burst_cnt_r;
  logic [CW-1:0]  cnt_nxt_s;
  logic [N-1:0]   grant_nxt_s;
  logic [IDW-1:0] id_nxt_s;

  logic [IDW-1:0] next_ptr_s;
  logic [IDW-1:0] pick_ptr_s;
  logic [N-1:0]   pick_mask_s;
  logic [N-1:0]   pick_win_s;
  logic [IDW-1:0] pick_id_s;
  logic           pick_any_s;
  logic           lock_hold_s;
  logic           held_req_s;
  logic           at_limit_s;
  logic           release_s;

`ifdef ARB_LOCK_EN
  assign lock_hold_s = lock;
`else
  assign lock_hold_s = 1'b0;
`endif

  assign next_ptr_s = IDW'(mod_inc(32'(grant_id), N));

  // Picker inputs: while granted, pick as if the pointer had already moved
  // past the holder, and exclude the holder for this one decision.
  always_comb begin
    pick_ptr_s  = pointer_r;
    pick_mask_s = {N{1'b0}};
    if (state_r == GRANT) begin
      pick_ptr_s  = next_ptr_s;
      pick_mask_s = grant;
    end else begin
      pick_ptr_s  = pointer_r;
      pick_mask_s = {N{1'b0}};
    end
  end

  arb_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req       (req),
    .pointer   (pick_ptr_s),
    .mask      (pick_mask_s),
    .winner    (pick_win_s),
    .winner_id (pick_id_s),
    .any       (pick_any_s)
  );

  // Release: burst limit reached on this ack (unless locked), or the holder
  // dropped its request (with or without a final ack).
  always_comb begin
    held_req_s = req[grant_id];
    at_limit_s = ack && (burst_cnt_r == CNT_LAST) && !lock_hold_s;
    release_s  = (state_r == GRANT) && (!held_req_s || at_limit_s);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s   = state_r;
    pointer_nxt_s = pointer_r;
    cnt_nxt_s     = burst_cnt_r;
    grant_nxt_s   = grant;
    id_nxt_s      = grant_id;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_nxt_s = GRANT;
          grant_nxt_s = pick_win_s;
          id_nxt_s    = pick_id_s;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          grant_nxt_s = {N{1'b0}};
          id_nxt_s    = {IDW{1'b0}};
        end
      end
      GRANT: begin
        if (release_s) begin
          pointer_nxt_s = next_ptr_s;
          cnt_nxt_s     = {CW{1'b0}};
          if (pick_any_s) begin
            state_nxt_s = GRANT;
            grant_nxt_s = pick_win_s;
            id_nxt_s    = pick_id_s;
          end else begin
            state_nxt_s = IDLE;
            grant_nxt_s = {N{1'b0}};
            id_nxt_s    = {IDW{1'b0}};
          end
        end else if (ack) begin
          // Only reachable past CNT_LAST-1 while locked; saturate there.
          if (burst_cnt_r != CNT_LAST) begin
            cnt_nxt_s = burst_cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            cnt_nxt_s = burst_cnt_r;
          end
        end else begin
          cnt_nxt_s = burst_cnt_r;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        pointer_nxt_s = {IDW{1'b0}};
        cnt_nxt_s     = {CW{1'b0}};
        grant_nxt_s   = {N{1'b0}};
        id_nxt_s      = {IDW{1'b0}};
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pointer_r   <= {IDW{1'b0}};
      burst_cnt_r <= {CW{1'b0}};
      grant       <= {N{1'b0}};
      grant_id    <= {IDW{1'b0}};
      grant_valid <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pointer_r   <= pointer_nxt_s;
      burst_cnt_r <= cnt_nxt_s;
      grant       <= grant_nxt_s;
      grant_id    <= id_nxt_s;
      grant_valid <= |grant_nxt_s;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_burst.sv
// Self-checking bench for rr_arbiter_burst: directed vectors with literal
// expectations plus a queue-free reference model compared every cycle.
// Build with ARB_LOCK_EN defined to also exercise the lock input.
module tb_rr_arbiter_burst;

  localparam int N         = 4;
  localparam int MAX_BURST = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         ack = 1'b0;
  logic         lock = 1'b0;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         grant_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arbiter_burst #(
    .N         (N),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ack         (ack),
`ifdef ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  // Reference model: owner index (-1 = nobody), rotating pointer, acks taken.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_acks  = 0;

  function automatic int search(input logic [N-1:0] r, input int from, input int skip);
    search = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (from + k) % N;
      if (search < 0 && r[idx] && idx != skip) search = idx;
    end
  endfunction

  function automatic logic [N-1:0] onehot(input int o);
    onehot = '0;
    if (o >= 0) onehot[o] = 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_acks  <= 0;
    end else if (m_owner < 0) begin
      m_owner <= search(req, m_ptr, -1);
      m_acks  <= 0;
    end else if (!req[m_owner] || (ack && (m_acks + 1 >= MAX_BURST) && !lock)) begin
      m_ptr   <= (m_owner + 1) % N;
      m_owner <= search(req, (m_owner + 1) % N, m_owner);
      m_acks  <= 0;
    end else if (ack) begin
      m_acks <= m_acks + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("model_grant", 32'(grant), 32'(onehot(m_owner)));
    chk("model_grant_id", 32'(grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("model_grant_valid", 32'(grant_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
  endtask

  // Drive one cycle's inputs, advance one edge, then compare against the model.
  task automatic cyc(input logic [N-1:0] r, input logic a, input logic rs, input logic lk);
    req  = r;
    ack  = a;
    rst  = rs;
    lock = lk;
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic lit(input string name, input logic [N-1:0] exp);
    chk(name, 32'(grant), 32'(exp));
  endtask

  initial begin
    // Reset
    cyc(4'b0000, 1'b0, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1, 1'b0);
    lit("reset_grant", 4'b0000);
    chk("reset_valid", 32'(grant_valid), 32'd0);

    // Idle: no requests, ack pulse ignored
    for (int i = 0; i < 10; i++) cyc(4'b0000, (i == 5), 1'b0, 1'b0);
    lit("idle_grant", 4'b0000);
    chk("idle_valid", 32'(grant_valid), 32'd0);

    // req=1010 from pointer 0, then 4 acks hand over to requester 3
    cyc(4'b1010, 1'b0, 1'b0, 1'b0);
    lit("first_grant", 4'b0010);
    chk("first_id", 32'(grant_id), 32'd1);
    for (int i = 0; i < 3; i++) cyc(4'b1010, 1'b1, 1'b0, 1'b0);
    lit("burst_hold", 4'b0010);
    cyc(4'b1010, 1'b1, 1'b0, 1'b0);
    lit("handover", 4'b1000);
    chk("handover_valid", 32'(grant_valid), 32'd1);

    // All requesting, ack every cycle: 0001,0010,0100,1000,0001 each 4 acks
    for (int i = 1; i <= 20; i++) begin
      cyc(4'b1111, 1'b1, 1'b0, 1'b0);
      if (i % 4 == 0) lit($sformatf("rotate_%0d", i / 4), onehot((i / 4 - 1) % N));
    end

    // Drop to idle (pointer moves to 1), then grant 2 and let it abandon
    cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    lit("abandon_idle", 4'b0000);
    cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    lit("grant_two", 4'b0100);
    cyc(4'b0100, 1'b1, 1'b0, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0, 1'b0);
    cyc(4'b1011, 1'b0, 1'b0, 1'b0);
    lit("abandon_next_is_3", 4'b1000);

    // Reset mid-burst: pointer must return to 0
    cyc(4'b1011, 1'b1, 1'b0, 1'b0);
    cyc(4'b1011, 1'b1, 1'b0, 1'b0);
    cyc(4'b1011, 1'b1, 1'b1, 1'b0);
    lit("midburst_reset", 4'b0000);
    cyc(4'b1111, 1'b0, 1'b0, 1'b0);
    lit("reset_ptr_zero", 4'b0001);
    cyc(4'b1111, 1'b1, 1'b0, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0, 1'b0);
    cyc(4'b1111, 1'b1, 1'b1, 1'b0);
    lit("midburst_reset2", 4'b0000);
    cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    lit("after_reset_grant", 4'b0100);

    // Lone requester: one idle cycle every MAX_BURST transfers
    for (int i = 0; i < 4; i++) cyc(4'b0100, 1'b1, 1'b0, 1'b0);
    lit("lone_gap", 4'b0000);
    cyc(4'b0100, 1'b1, 1'b0, 1'b0);
    lit("lone_regrant", 4'b0100);

    // Ack while holder drops request releases to the next in line
    cyc(4'b0001, 1'b1, 1'b0, 1'b0);
    lit("ack_drop", 4'b0001);
    chk("ack_drop_id", 32'(grant_id), 32'd0);

`ifdef ARB_LOCK_EN
    cyc(4'b0000, 1'b0, 1'b1, 1'b0);
    cyc(4'b0011, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(4'b0011, 1'b1, 1'b0, 1'b1);
    lit("lock_hold", 4'b0001);
    cyc(4'b0011, 1'b1, 1'b0, 1'b0);
    lit("lock_release", 4'b0010);
`endif

    // Mixed traffic checked against the model only
    for (int i = 0; i < 300; i++) begin
      cyc(N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 49) == 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
